alu_result_tx: RTL and testbench
================================

# alu_result_tx

Serial transmitter that returns the slave ALU's outcome to the master board. On a start pulse it captures the WIDTH-bit result and the N/Z/C/V flags, then shifts them out as one UART-style frame on a single line. It sits between the ALU outputs and the FPGA pin wired to the master's receive input. It is the return path of the master-to-slave operand link.

## Interface
- WIDTH, 4: ALU result width in bits.
- CLKS_PER_BIT, 5208: clock cycles per serial bit (50 MHz / 9600 baud). Must be ≥ 2.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to send the current result and flags.
- result  in  WIDTH  ALU result to send.
- n, z, c, v  in  1 each  ALU flags to send.
- tx  out  1  serial line; idle level is high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.

## Operation
- Payload is P = {n, z, c, v, result}, WIDTH+4 bits, sent LSB first. result[0] goes first; n goes last.
- Frame order:
  - start bit (0);
  - P[0] through P[WIDTH+3];
  - parity bit, only when configured (see Configuration);
  - stop bit (1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when start=1. In that same edge, P is latched into a shift register.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA stays in DATA for WIDTH+4 bits. It then goes to PARITY when parity is compiled in, otherwise to STOP.
  - PARITY → STOP after CLKS_PER_BIT cycles.
  - STOP → IDLE after CLKS_PER_BIT cycles.
- A bit counter counts data bits 0..WIDTH+3. A baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- start is ignored while busy=1. It is not queued.
- Changes to the inputs after capture do not affect the frame in progress.
- Reset values: tx=1, busy=0, done=0, FSM=IDLE, both counters=0, shift register=0.

## Timing
- tx, busy and done are registered outputs.
- Start is sampled at edge k:
  - tx=0 and busy=1 from edge k.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length F = (WIDTH+6+parity) × CLKS_PER_BIT cycles, where parity is 1 when compiled in and 0 otherwise.
- At edge k+F: done=1 for one cycle, busy=0, tx=1.
  - A start sampled in that same cycle is accepted, giving back-to-back frames with no idle bit.
- rst mid-frame: on the next edge tx=1, busy=0, done=0 and the FSM is IDLE. The partial frame is abandoned.
- rst together with start: rst wins and the frame is not started.

## Configuration
- ALU_TX_PARITY_EN defined:
  - An even-parity bit is sent after the payload. Its value is the XOR of all WIDTH+4 payload bits.
  - The PARITY state exists.
  - F includes one extra bit time.
- ALU_TX_PARITY_EN undefined:
  - No parity bit is sent and the PARITY state is not compiled.
  - DATA goes directly to STOP.

## Structure
- Package alu_link_pkg contains:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - the localparam PAYLOAD_W = WIDTH+4 helper function;
  - the line levels IDLE_LVL=1 and START_LVL=0.
- One sub-module, alu_baud_tick:
  - parameter CLKS_PER_BIT; ports clk, rst, en, tick;
  - tick is a one-cycle pulse on the last cycle of each bit period;
  - the counter is held at 0 while en=0.

## Test plan
Bench settings: WIDTH=4, CLKS_PER_BIT=4.
- Reset idle:
  - Stimulus: assert rst for 3 cycles with start=1.
  - Required: tx=1, busy=0, done=0 throughout; no frame after release.
- Basic frame, parity undefined:
  - Stimulus: result=4'b0110, n=0, z=0, c=1, v=0, one start pulse.
  - Required: tx sampled mid-bit reads 0, 0,1,1,0,0,1,0,0, 1.
  - Required: busy high for 40 cycles; done pulses at cycle 40.
- Parity defined, same stimulus:
  - Required: the bit after the payload is 1 (three ones in payload 0x26).
  - Required: frame is 44 cycles long.
- Ignored start:
  - Stimulus: a second start at cycle 10 of a frame, with different inputs.
  - Required: the frame is unchanged; no second frame follows.
- Back-to-back:
  - Stimulus: start asserted in the done cycle, with result=4'b0000, z=1.
  - Required: the next start bit begins immediately; payload bits read 0,0,0,0,0,0,1,0.
- Reset mid-frame:
  - Stimulus: assert rst during DATA bit 3.
  - Required: next cycle tx=1, busy=0, done never pulses.
  - Required: a later start sends a full, correct frame.

Source files
------------

// File: rtl/alu_link_pkg.sv
// Shared types and constants for the ALU result return link.
// The transmitter's optional parity bit is controlled by the ALU_TX_PARITY_EN macro.
package alu_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  // Payload is the result plus the four N/Z/C/V flags.
  function automatic int payload_w(input int width);
    return width + 4;
  endfunction

endpackage

// File: rtl/alu_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period; held at zero while disabled.
module alu_baud_tick #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/alu_result_tx.sv
// Serial return path for the slave ALU: start bit, {n,z,c,v,result} LSB first,
// optional even parity (ALU_TX_PARITY_EN), stop bit.
module alu_result_tx
  import alu_link_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] result,
  input  logic             n,
  input  logic             z,
  input  logic             c,
  input  logic             v,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int PW    = payload_w(WIDTH);
  localparam int BIT_W = $clog2(PW);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PW - 1);

  tx_state_t        state;
  logic [PW-1:0]    shift;
  logic [BIT_W-1:0] bit_cnt;
  logic             bit_en;
  logic             tick;
`ifdef ALU_TX_PARITY_EN
  logic             par;
`endif

  assign bit_en = (state != IDLE);

  alu_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .en  (bit_en),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= IDLE_LVL;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef ALU_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift   <= {n, z, c, v, result};
`ifdef ALU_TX_PARITY_EN
            par     <= ^{n, z, c, v, result};
`endif
            bit_cnt <= '0;
            tx      <= START_LVL;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx    <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef ALU_TX_PARITY_EN
              tx      <= par;
              state   <= PARITY;
`else
              tx      <= IDLE_LVL;
              state   <= STOP;
`endif
            end else begin
              // tx takes the next bit while the register shifts past it
              bit_cnt <= bit_cnt + BIT_W'(1);
              shift   <= {1'b0, shift[PW-1:1]};
              tx      <= shift[1];
            end
          end
        end
`ifdef ALU_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx    <= IDLE_LVL;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            tx    <= IDLE_LVL;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx with WIDTH=4, CLKS_PER_BIT=4; follows ALU_TX_PARITY_EN.
module tb_alu_result_tx;

  localparam int WIDTH = 4;
  localparam int CPB   = 4;
`ifdef ALU_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB  = WIDTH + 6 + PAR;
  localparam int F   = NB * CPB;
  localparam int MID = CPB / 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] result;
  logic             n, z, c, v;
  logic             tx, busy, done;

  int errors = 0;
  int checks = 0;

  logic txs [0:63];
  logic bsy [0:63];
  logic dn  [0:63];

  alu_result_tx #(
    .WIDTH(WIDTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .result(result),
    .n(n),
    .z(z),
    .c(c),
    .v(v),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Frame bit b for a hand-computed payload byte p and parity pb.
  function automatic logic expbit(input logic [7:0] p, input logic pb, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return p[3'(b - 1)];
    if (PAR == 1 && b == 9) return pb;
    return 1'b1;
  endfunction

  task automatic kick(input logic [3:0] r, input logic [3:0] fl);
    @(negedge clk);
    result = r;
    {n, z, c, v} = fl;
    start = 1'b1;
  endtask

  // Records samples 0..F of a frame whose start was raised at the previous negedge.
  // Optionally raises a new start (with new inputs) at sample inject_at.
  task automatic capture(input int inject_at, input logic [3:0] ir, input logic [3:0] ifl);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= F; i++) begin
      txs[i] = tx;
      bsy[i] = busy;
      dn[i]  = done;
      if (i == inject_at) begin
        start = 1'b1;
        result = ir;
        {n, z, c, v} = ifl;
      end else if (i == inject_at + 1) begin
        start = 1'b0;
      end
      if (i < F) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    start = 1'b1;
    result = 4'b1010;
    {n, z, c, v} = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    end
    rst = 1'b0;
    start = 1'b0;
    bad = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_no_frame got=%0d active samples exp=0", bad); end
  endtask

  task automatic test_basic_frame();
    int bcnt, dcnt;
    kick(4'b0110, 4'b0010);
    capture(-1, 4'b0000, 4'b0000);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (txs[b*CPB+MID] !== expbit(8'h26, 1'b1, b)) begin
        errors++;
        $display("FAIL basic_bit%0d got=%b exp=%b", b, txs[b*CPB+MID], expbit(8'h26, 1'b1, b));
      end
    end
    bcnt = 0;
    dcnt = 0;
    for (int i = 0; i <= F; i++) begin
      if (bsy[i] === 1'b1) bcnt++;
      if (dn[i] === 1'b1) dcnt++;
    end
    checks++;
    if (bcnt != F) begin errors++; $display("FAIL basic_busy_len got=%0d exp=%0d", bcnt, F); end
    checks++;
    if (dn[F] !== 1'b1 || dcnt != 1) begin
      errors++;
      $display("FAIL basic_done got=%b count=%0d exp=1 count=1", dn[F], dcnt);
    end
    checks++;
    if (txs[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_cycle got tx=%b busy=%b exp tx=0 busy=1", txs[0], bsy[0]);
    end
    checks++;
    if (txs[F] !== 1'b1) begin errors++; $display("FAIL basic_tx_after got=%b exp=1", txs[F]); end
  endtask

  task automatic test_parity();
    logic exp9;
    // payload 0x87 has four ones: parity 0 when enabled, otherwise this slot is the stop bit
    exp9 = (PAR == 1) ? 1'b0 : 1'b1;
    kick(4'b0111, 4'b1000);
    capture(-1, 4'b0000, 4'b0000);
    checks++;
    if (txs[9*CPB+MID] !== exp9) begin
      errors++;
      $display("FAIL parity_bit got=%b exp=%b", txs[9*CPB+MID], exp9);
    end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (txs[b*CPB+MID] !== expbit(8'h87, 1'b0, b)) begin
        errors++;
        $display("FAIL parity_frame_bit%0d got=%b exp=%b", b, txs[b*CPB+MID], expbit(8'h87, 1'b0, b));
      end
    end
    checks++;
    if (bsy[F-1] !== 1'b1 || bsy[F] !== 1'b0 || dn[F] !== 1'b1) begin
      errors++;
      $display("FAIL parity_len got busy_last=%b busy_end=%b done=%b exp 1 0 1", bsy[F-1], bsy[F], dn[F]);
    end
  endtask

  task automatic test_ignored_start();
    int bcnt, dcnt, late;
    kick(4'b0110, 4'b0010);
    capture(10, 4'b1111, 4'b1101);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (txs[b*CPB+MID] !== expbit(8'h26, 1'b1, b)) begin
        errors++;
        $display("FAIL ignored_bit%0d got=%b exp=%b", b, txs[b*CPB+MID], expbit(8'h26, 1'b1, b));
      end
    end
    bcnt = 0;
    dcnt = 0;
    for (int i = 0; i <= F; i++) begin
      if (bsy[i] === 1'b1) bcnt++;
      if (dn[i] === 1'b1) dcnt++;
    end
    checks++;
    if (bcnt != F || dcnt != 1) begin
      errors++;
      $display("FAIL ignored_len got busy=%0d done=%0d exp busy=%0d done=1", bcnt, dcnt, F);
    end
    late = 0;
    repeat (2 * F) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL ignored_second_frame got=%0d active samples exp=0", late); end
  endtask

  task automatic test_back_to_back();
    kick(4'b0110, 4'b0010);
    capture(F, 4'b0000, 4'b0100);
    checks++;
    if (dn[F] !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", dn[F]); end
    capture(-1, 4'b0000, 4'b0000);
    checks++;
    if (txs[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_immediate got tx=%b busy=%b exp tx=0 busy=1", txs[0], bsy[0]);
    end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (txs[b*CPB+MID] !== expbit(8'h40, 1'b1, b)) begin
        errors++;
        $display("FAIL b2b_bit%0d got=%b exp=%b", b, txs[b*CPB+MID], expbit(8'h40, 1'b1, b));
      end
    end
    checks++;
    if (dn[F] !== 1'b1 || bsy[F] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_done got done=%b busy=%b exp 1 0", dn[F], bsy[F]);
    end
  endtask

  task automatic test_reset_mid();
    int act;
    kick(4'b0110, 4'b0010);
    @(negedge clk);
    start = 1'b0;
    // sample 17 lies inside data bit 3 (frame bit 4)
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got tx=%b busy=%b done=%b exp 1 0 0", tx, busy, done);
    end
    rst = 1'b0;
    act = 0;
    repeat (F) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) act++;
    end
    checks++;
    if (act != 0) begin errors++; $display("FAIL midrst_quiet got=%0d active samples exp=0", act); end
    kick(4'b0111, 4'b1000);
    capture(-1, 4'b0000, 4'b0000);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (txs[b*CPB+MID] !== expbit(8'h87, 1'b0, b)) begin
        errors++;
        $display("FAIL midrst_bit%0d got=%b exp=%b", b, txs[b*CPB+MID], expbit(8'h87, 1'b0, b));
      end
    end
    checks++;
    if (dn[F] !== 1'b1) begin errors++; $display("FAIL midrst_done got=%b exp=1", dn[F]); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    result = '0;
    {n, z, c, v} = 4'b0000;
    test_reset();
    test_basic_frame();
    test_parity();
    test_ignored_start();
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
